multicycle_control_path: RTL and testbench

- Control and execute block for the multicycle RV32I core.
- Contains the Moore FSM that sequences fetch, decode, execute, memory and writeback, plus ALU-operation decode and a combinational 32-bit ALU.
- Drives the core's mux selects, memory strobes, IR/PC/register-file enables and `pc_write_cond`; the core ANDs `pc_write_cond` with `zero`.

---
 rtl/multicycle_control_path_pkg.sv | 61 ++++++
 rtl/multicycle_control_path_rv_alu.sv | 71 +++++++
 rtl/multicycle_control_path.sv | 168 ++++++++++++++++
 tb/tb_multicycle_control_path.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_path_pkg.sv
// rtl/multicycle_control_path_pkg.sv - shared opcodes, ALU codes, mux selects and FSM states
package multicycle_control_path_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_SGE  = 4'b1010,
    ALU_SGEU = 4'b1011,
    ALU_SEQ  = 4'b1100,
    ALU_ONE  = 4'b1111
  } alu_op_e;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNC   = 2'b10;

  localparam logic [1:0] SRC_A_PC   = 2'd0;
  localparam logic [1:0] SRC_A_RS1  = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_FOUR = 2'd1;
  localparam logic [1:0] SRC_B_IMM  = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_LOAD_WB   = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_LUI       = 4'd8,
    S_ALU_WB    = 4'd9,
    S_BRANCH    = 4'd10,
    S_JALR_ADDR = 4'd11,
    S_LINK      = 4'd12,
    S_LINK_WB   = 4'd13,
    S_PC_INC    = 4'd14
  } state_e;

endpackage

// File: rtl/multicycle_control_path_rv_alu.sv
// rtl/multicycle_control_path_rv_alu.sv - ALU-operation decode and combinational 32-bit ALU
module rv_alu
  import multicycle_control_path_pkg::*;
(
  input  logic [1:0]  aluop,
  input  logic [2:0]  func3,
  input  logic        func7_5,
  input  logic        is_imm,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] result,
  output logic        zero
);

  alu_op_e op;

  // Branches pick the inverse compare so that a zero result means taken.
  always_comb begin
    op = ALU_ADD;
    case (aluop)
      ALUOP_BRANCH: begin
        case (func3)
          3'b000:  op = ALU_SUB;
          3'b001:  op = ALU_SEQ;
          3'b100:  op = ALU_SGE;
          3'b101:  op = ALU_SLT;
          3'b110:  op = ALU_SGEU;
          3'b111:  op = ALU_SLTU;
          default: op = ALU_ONE;
        endcase
      end
      ALUOP_FUNC: begin
        case (func3)
          3'b000:  op = (!is_imm && func7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  op = ALU_SLL;
          3'b010:  op = ALU_SLT;
          3'b011:  op = ALU_SLTU;
          3'b100:  op = ALU_XOR;
          3'b101:  op = func7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  op = ALU_OR;
          default: op = ALU_AND;
        endcase
      end
      default: op = ALU_ADD;
    endcase
  end

  always_comb begin
    result = '0;
    case (op)
      ALU_AND:  result = x & y;
      ALU_OR:   result = x | y;
      ALU_ADD:  result = x + y;
      ALU_XOR:  result = x ^ y;
      ALU_SLL:  result = x << y[4:0];
      ALU_SRL:  result = x >> y[4:0];
      ALU_SUB:  result = x - y;
      ALU_SRA:  result = $unsigned($signed(x) >>> y[4:0]);
      ALU_SLT:  result = {31'd0, $signed(x) < $signed(y)};
      ALU_SLTU: result = {31'd0, x < y};
      ALU_SGE:  result = {31'd0, $signed(x) >= $signed(y)};
      ALU_SGEU: result = {31'd0, x >= y};
      ALU_SEQ:  result = {31'd0, x == y};
      ALU_ONE:  result = 32'd1;
      default:  result = '0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/multicycle_control_path.sv
// rtl/multicycle_control_path.sv - multicycle RV32I Moore control FSM plus ALU
module multicycle_control_path
  import multicycle_control_path_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  input  logic [31:0] alu_in_x,
  input  logic [31:0] alu_in_y,
  output logic [31:0] alu_out,
  output logic        zero,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        lord,
  output logic        memory_read,
  output logic        memory_write,
  output logic        memory_to_reg,
  output logic        ir_write,
  output logic        pc_source,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        reg_write
);

  state_e     state_q, state_d;
  logic [1:0] aluop;
  logic       is_imm;

  // Only func7[5] distinguishes operations in RV32I.
  logic func7_unused;
  assign func7_unused = ^{func7[6], func7[4:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    lord          = 1'b0;
    memory_read   = 1'b0;
    memory_write  = 1'b0;
    memory_to_reg = 1'b0;
    ir_write      = 1'b0;
    pc_source     = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    aluop         = ALUOP_ADD;
    is_imm        = 1'b0;
    case (state_q)
      S_FETCH: begin
        memory_read = 1'b1;
        ir_write    = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        // ALU-out register captures PC+imm for AUIPC, JAL and branch targets.
        alu_src_b = SRC_B_IMM;
        case (opcode)
          OPC_LOAD, OPC_STORE: state_d = S_MEM_ADDR;
          OPC_OP:              state_d = S_EXEC_R;
          OPC_OP_IMM:          state_d = S_EXEC_I;
          OPC_BRANCH:          state_d = S_BRANCH;
          OPC_JAL:             state_d = S_LINK;
          OPC_JALR:            state_d = S_JALR_ADDR;
          OPC_LUI:             state_d = S_LUI;
          OPC_AUIPC:           state_d = S_ALU_WB;
          default:             state_d = S_PC_INC;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        state_d   = (opcode == OPC_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        alu_src_a   = SRC_A_RS1;
        alu_src_b   = SRC_B_IMM;
        lord        = 1'b1;
        memory_read = 1'b1;
        state_d     = S_LOAD_WB;
      end
      S_LOAD_WB: begin
        memory_to_reg = 1'b1;
        reg_write     = 1'b1;
        state_d       = S_PC_INC;
      end
      S_MEM_WRITE: begin
        alu_src_a    = SRC_A_RS1;
        alu_src_b    = SRC_B_IMM;
        lord         = 1'b1;
        memory_write = 1'b1;
        state_d      = S_PC_INC;
      end
      S_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        aluop     = ALUOP_FUNC;
        state_d   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        aluop     = ALUOP_FUNC;
        is_imm    = 1'b1;
        state_d   = S_ALU_WB;
      end
      S_LUI: begin
        alu_src_a = SRC_A_ZERO;
        alu_src_b = SRC_B_IMM;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        state_d   = S_PC_INC;
      end
      S_BRANCH: begin
        alu_src_a     = SRC_A_RS1;
        alu_src_b     = SRC_B_RS2;
        aluop         = ALUOP_BRANCH;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        state_d       = zero ? S_FETCH : S_PC_INC;
      end
      S_JALR_ADDR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        state_d   = S_LINK;
      end
      S_LINK: begin
        // PC takes the held target while the ALU computes the link value PC+4.
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        pc_write  = 1'b1;
        pc_source = 1'b1;
        state_d   = S_LINK_WB;
      end
      S_LINK_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_PC_INC: begin
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  rv_alu u_alu (
    .aluop   (aluop),
    .func3   (func3),
    .func7_5 (func7[5]),
    .is_imm  (is_imm),
    .x       (alu_in_x),
    .y       (alu_in_y),
    .result  (alu_out),
    .zero    (zero)
  );

endmodule

// File: tb/tb_multicycle_control_path.sv
// tb/tb_multicycle_control_path.sv - directed self-checking bench for multicycle_control_path
module tb_multicycle_control_path;
  import multicycle_control_path_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = '0;
  logic [2:0]  func3 = '0;
  logic [6:0]  func7 = '0;
  logic [31:0] alu_in_x = '0;
  logic [31:0] alu_in_y = '0;
  logic [31:0] alu_out;
  logic        zero, pc_write, pc_write_cond, lord, memory_read, memory_write;
  logic        memory_to_reg, ir_write, pc_source, reg_write;
  logic [1:0]  alu_src_a, alu_src_b;

  int errors = 0;
  int checks = 0;

  // {pc_write, pc_write_cond, lord, memory_read, memory_write, memory_to_reg,
  //  ir_write, pc_source, reg_write, alu_src_a, alu_src_b}
  localparam logic [12:0] C_FETCH     = 13'b0001001000000;
  localparam logic [12:0] C_DECODE    = 13'b0000000000010;
  localparam logic [12:0] C_MEM_ADDR  = 13'b0000000000110;
  localparam logic [12:0] C_MEM_READ  = 13'b0011000000110;
  localparam logic [12:0] C_LOAD_WB   = 13'b0000010010000;
  localparam logic [12:0] C_MEM_WRITE = 13'b0010100000110;
  localparam logic [12:0] C_EXEC_R    = 13'b0000000000100;
  localparam logic [12:0] C_EXEC_I    = 13'b0000000000110;
  localparam logic [12:0] C_LUI       = 13'b0000000001010;
  localparam logic [12:0] C_ALU_WB    = 13'b0000000010000;
  localparam logic [12:0] C_BRANCH    = 13'b0100000100100;
  localparam logic [12:0] C_JALR_ADDR = 13'b0000000000110;
  localparam logic [12:0] C_LINK      = 13'b1000000100001;
  localparam logic [12:0] C_LINK_WB   = 13'b0000000010000;
  localparam logic [12:0] C_PC_INC    = 13'b1000000000001;

  wire [12:0] ctl = {pc_write, pc_write_cond, lord, memory_read, memory_write, memory_to_reg,
                     ir_write, pc_source, reg_write, alu_src_a, alu_src_b};

  multicycle_control_path dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func3(func3), .func7(func7),
    .alu_in_x(alu_in_x), .alu_in_y(alu_in_y), .alu_out(alu_out), .zero(zero),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .lord(lord),
    .memory_read(memory_read), .memory_write(memory_write), .memory_to_reg(memory_to_reg),
    .ir_write(ir_write), .pc_source(pc_source), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .reg_write(reg_write)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    opcode = o;
    func3  = f3;
    func7  = f7;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (dut.state_q !== S_FETCH || ctl !== C_FETCH) begin
      errors++;
      $display("FAIL reset: state=%0d ctl=%b, expected state=%0d ctl=%b", dut.state_q, ctl, S_FETCH, C_FETCH);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add();
    state_e st [6];
    logic [12:0] cv [6];
    st = '{S_FETCH, S_DECODE, S_EXEC_R, S_ALU_WB, S_PC_INC, S_FETCH};
    cv = '{C_FETCH, C_DECODE, C_EXEC_R, C_ALU_WB, C_PC_INC, C_FETCH};
    alu_in_x = 32'd7;
    alu_in_y = 32'd5;
    restart(OPC_OP, 3'b000, 7'h00);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      checks++;
      if (dut.state_q !== st[i] || ctl !== cv[i]) begin
        errors++;
        $display("FAIL add step %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, dut.state_q, ctl, st[i], cv[i]);
      end
      if (st[i] == S_EXEC_R) begin
        checks++;
        if (alu_out !== 32'd12) begin
          errors++;
          $display("FAIL add result: got %h, expected %h", alu_out, 32'd12);
        end
      end
    end
  endtask

  task automatic test_sub_sra();
    restart(OPC_OP, 3'b000, 7'b0100000);
    step();
    step();
    alu_in_x = 32'd5;
    alu_in_y = 32'd7;
    #1;
    checks++;
    if (dut.state_q !== S_EXEC_R || alu_out !== 32'hFFFF_FFFE || zero !== 1'b0) begin
      errors++;
      $display("FAIL sub: state=%0d out=%h zero=%b, expected state=%0d out=fffffffe zero=0", dut.state_q, alu_out, zero, S_EXEC_R);
    end
    func3 = 3'b101;
    alu_in_x = 32'h8000_0000;
    alu_in_y = 32'd4;
    #1;
    checks++;
    if (alu_out !== 32'hF800_0000) begin
      errors++;
      $display("FAIL sra: got %h, expected f8000000", alu_out);
    end
    func7 = 7'h00;
    #1;
    checks++;
    if (alu_out !== 32'h0800_0000) begin
      errors++;
      $display("FAIL srl: got %h, expected 08000000", alu_out);
    end
    restart(OPC_OP_IMM, 3'b000, 7'b0100000);
    step();
    step();
    alu_in_x = 32'd5;
    alu_in_y = 32'd7;
    #1;
    checks++;
    if (dut.state_q !== S_EXEC_I || ctl !== C_EXEC_I || alu_out !== 32'd12) begin
      errors++;
      $display("FAIL addi: state=%0d ctl=%b out=%h, expected state=%0d ctl=%b out=0000000c", dut.state_q, ctl, alu_out, S_EXEC_I, C_EXEC_I);
    end
  endtask

  task automatic test_branch();
    logic [2:0]  f3 [4];
    logic [31:0] xv [4];
    logic [31:0] yv [4];
    logic        zv [4];
    state_e      nx [4];
    f3 = '{3'b000, 3'b000, 3'b100, 3'b001};
    xv = '{32'd9, 32'd9, 32'hFFFF_FFFF, 32'd3};
    yv = '{32'd9, 32'd8, 32'd0, 32'd3};
    zv = '{1'b1, 1'b0, 1'b1, 1'b0};
    nx = '{S_FETCH, S_PC_INC, S_FETCH, S_PC_INC};
    for (int i = 0; i < 4; i++) begin
      alu_in_x = xv[i];
      alu_in_y = yv[i];
      restart(OPC_BRANCH, f3[i], 7'h00);
      step();
      step();
      checks++;
      if (dut.state_q !== S_BRANCH || ctl !== C_BRANCH || zero !== zv[i]) begin
        errors++;
        $display("FAIL branch %0d: state=%0d ctl=%b zero=%b, expected state=%0d ctl=%b zero=%b", i, dut.state_q, ctl, zero, S_BRANCH, C_BRANCH, zv[i]);
      end
      step();
      checks++;
      if (dut.state_q !== nx[i]) begin
        errors++;
        $display("FAIL branch %0d next: state=%0d, expected %0d", i, dut.state_q, nx[i]);
      end
    end
  endtask

  task automatic test_load_store();
    state_e st [6];
    logic [12:0] cv [6];
    st = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_LOAD_WB, S_PC_INC};
    cv = '{C_FETCH, C_DECODE, C_MEM_ADDR, C_MEM_READ, C_LOAD_WB, C_PC_INC};
    restart(OPC_LOAD, 3'b010, 7'h00);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      checks++;
      if (dut.state_q !== st[i] || ctl !== cv[i]) begin
        errors++;
        $display("FAIL lw step %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, dut.state_q, ctl, st[i], cv[i]);
      end
    end
    st = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_WRITE, S_PC_INC, S_FETCH};
    cv = '{C_FETCH, C_DECODE, C_MEM_ADDR, C_MEM_WRITE, C_PC_INC, C_FETCH};
    restart(OPC_STORE, 3'b010, 7'h00);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      checks++;
      if (dut.state_q !== st[i] || ctl !== cv[i]) begin
        errors++;
        $display("FAIL sw step %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, dut.state_q, ctl, st[i], cv[i]);
      end
    end
  endtask

  task automatic test_jumps();
    state_e st [6];
    logic [12:0] cv [6];
    st = '{S_FETCH, S_DECODE, S_LINK, S_LINK_WB, S_FETCH, S_DECODE};
    cv = '{C_FETCH, C_DECODE, C_LINK, C_LINK_WB, C_FETCH, C_DECODE};
    restart(OPC_JAL, 3'b000, 7'h00);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      checks++;
      if (dut.state_q !== st[i] || ctl !== cv[i]) begin
        errors++;
        $display("FAIL jal step %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, dut.state_q, ctl, st[i], cv[i]);
      end
    end
    st = '{S_FETCH, S_DECODE, S_JALR_ADDR, S_LINK, S_LINK_WB, S_FETCH};
    cv = '{C_FETCH, C_DECODE, C_JALR_ADDR, C_LINK, C_LINK_WB, C_FETCH};
    restart(OPC_JALR, 3'b000, 7'h00);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      checks++;
      if (dut.state_q !== st[i] || ctl !== cv[i]) begin
        errors++;
        $display("FAIL jalr step %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, dut.state_q, ctl, st[i], cv[i]);
      end
    end
  endtask

  task automatic test_misc_opcodes();
    logic [6:0]  op [3];
    state_e      s2 [3];
    logic [12:0] c2 [3];
    op = '{OPC_LUI, OPC_AUIPC, 7'b1110011};
    s2 = '{S_LUI, S_ALU_WB, S_PC_INC};
    c2 = '{C_LUI, C_ALU_WB, C_PC_INC};
    for (int i = 0; i < 3; i++) begin
      restart(op[i], 3'b000, 7'h00);
      step();
      step();
      checks++;
      if (dut.state_q !== s2[i] || ctl !== c2[i]) begin
        errors++;
        $display("FAIL opcode %b: state=%0d ctl=%b, expected state=%0d ctl=%b", op[i], dut.state_q, ctl, s2[i], c2[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    restart(OPC_STORE, 3'b010, 7'h00);
    step();
    step();
    step();
    checks++;
    if (dut.state_q !== S_MEM_WRITE || memory_write !== 1'b1) begin
      errors++;
      $display("FAIL reach mem_write: state=%0d memory_write=%b, expected state=%0d memory_write=1", dut.state_q, memory_write, S_MEM_WRITE);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (dut.state_q !== S_FETCH || ctl !== C_FETCH || memory_write !== 1'b0) begin
      errors++;
      $display("FAIL async reset: state=%0d ctl=%b, expected state=%0d ctl=%b", dut.state_q, ctl, S_FETCH, C_FETCH);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    checks++;
    if (dut.state_q !== S_DECODE) begin
      errors++;
      $display("FAIL after reset: state=%0d, expected %0d", dut.state_q, S_DECODE);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_sra();
    test_branch();
    test_load_store();
    test_jumps();
    test_misc_opcodes();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
